backprop_engine_n: RTL and testbench
====================================

BACKPROP_ENGINE_N -- requirements
Module: backprop_engine_n

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels (weights); range 1..64.
REQ-002 SHALL have parameter W, default 32: signed word width of every data port.
REQ-003 SHALL have parameter FRAC, default 16: fractional bits of the fixed-point format.
REQ-004 SHALL have port bpn_clk, input, 1: the only clock; reset is synchronous and active-high.
REQ-005 SHALL have port bpn_rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port bpn_in_valid, input, 1: input job offered.
REQ-007 SHALL have port bpn_in_ready, output, 1: engine accepts a job.
REQ-008 SHALL have port bpn_p, input, N_CH*W: per-channel activations, channel i at bits [i*W +: W].
REQ-009 SHALL have port bpn_w, input, N_CH*W: per-channel weights, same packing.
REQ-010 SHALL have port bpn_bp, input, W: back-propagated error.
REQ-011 SHALL have port bpn_tm, input, W: learning-rate numerator (signed integer).
REQ-012 SHALL have port bpn_td, input, W: learning-rate denominator (signed integer).
REQ-013 SHALL have port bpn_out_valid, output, 1: results valid.
REQ-014 SHALL have port bpn_out_ready, input, 1: consumer takes results.
REQ-015 SHALL have port bpn_bpc, output, N_CH*W: per-channel error passed upstream.
REQ-016 SHALL have port bpn_wn, output, N_CH*W: per-channel updated weights.
REQ-017 SHALL have port bpn_div_err, output, 1: bpn_td was zero for the current result.

Function
REQ-018 SHALL implement states IDLE, ACCUM, UPDATE, DONE.
REQ-019 SHALL assert bpn_in_ready only in IDLE; a job is accepted on a clock edge with bpn_in_valid & bpn_in_ready, all inputs being registered, then IDLE->ACCUM.
REQ-020 ACCUM SHALL run N_CH cycles, one channel per cycle, accumulating sum += p[i]*w[i] in a 2W+clog2(N_CH)-bit signed register without loss; it then moves to UPDATE.
REQ-021 Gate SHALL be 1 when the final sum >= 0 (zero counts as active), else 0.
REQ-022 UPDATE SHALL run N_CH cycles, one channel per cycle, writing bpc[i] = gate ? sat_W((w[i]*bp) >>> FRAC) : 0.
REQ-023 UPDATE SHALL write wn[i] = sat_W(w[i] - gate*trunc0(((p[i]*bp) >>> FRAC) * tm / (2*td))), computed at full width; trunc0 truncates toward zero and >>> is arithmetic.
REQ-024 If td == 0, the engine SHALL write wn[i] = w[i] for every channel, compute bpc normally, and set bpn_div_err for that result.
REQ-025 sat_W SHALL clamp to [-2^(W-1), 2^(W-1)-1].
REQ-026 After the last UPDATE cycle the engine SHALL enter DONE; bpn_out_valid SHALL be high only in DONE, first in cycle 2*N_CH+1 when the accept edge is cycle 0.
REQ-027 In DONE, bpn_bpc, bpn_wn and bpn_div_err SHALL stay stable until an edge with bpn_out_ready=1, which moves to IDLE; no job is accepted in that same cycle.
REQ-028 Outputs SHALL hold their last values in IDLE, ACCUM and UPDATE; bpn_in_valid is ignored outside IDLE.

Reset
REQ-029 While bpn_rst is high at a clock edge: state -> IDLE; bpn_out_valid=0; bpn_in_ready=1 on the following cycle; bpn_bpc=0; bpn_wn=0; bpn_div_err=0; accumulator=0; channel counter=0.
REQ-030 Reset mid-job SHALL abandon the job with no partial result visible.

Structure
REQ-031 Shared package backprop_pkg SHALL hold the state enum, default FRAC, and a sat_W function.
REQ-032 Sub-module fixed_mul (signed W x W multiply with FRAC shift and saturation) SHALL be instantiated once and time-shared across channels.

Verification (N_CH=4, W=32, FRAC=16; 1.0=0x00010000)
REQ-033 All p=1.0, w=0.5 (0x8000), bp=1.0, tm=1, td=1 -> out_valid in cycle 9; every bpc=0x00008000; every wn=0x00000000; div_err=0.
REQ-034 All w=-0.5 (0xFFFF8000), other inputs as REQ-033 -> gate 0; every bpc=0; every wn=0xFFFF8000.
REQ-035 REQ-033 inputs with td=0 -> div_err=1; every wn=0x00008000; every bpc=0x00008000.
REQ-036 All p=0x7FFF0000, bp=0x7FFF0000, w=0, tm=1, td=1 -> sum 0 so gate 1; every wn=0x80000000; every bpc=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, nothing accepted; in_ready=1 the cycle after out_ready=1.
REQ-038 Assert bpn_rst in cycle 3 of a job -> next cycle in_ready=1, out_valid=0, all outputs 0; a fresh REQ-033 job then completes correctly.

Source files
------------

// File: rtl/backprop_pkg.sv
// Shared types and helpers for the back-propagation engine: FSM state
// encoding, default fixed-point format and the signed saturation helper.
package backprop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_UPDATE,
        ST_DONE
    } bpn_state_t;

    localparam int DEFAULT_FRAC = 16;

    // Widest intermediate any caller may hand to sat_w (callers sign-extend into it).
    localparam int SAT_MAX_W = 256;

    function automatic logic signed [SAT_MAX_W-1:0] sat_w(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] one;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        logic signed [SAT_MAX_W-1:0] r;
        one = SAT_MAX_W'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = ~hi;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/backprop_engine_n_fixed_mul.sv
// Signed W x W multiplier: exposes the exact 2W-bit product and the
// FRAC-shifted product saturated back to W bits.
module fixed_mul
    import backprop_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = DEFAULT_FRAC
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] prod,
    output logic signed [W-1:0]   res
);

    localparam int W2 = 2 * W;

    logic signed [W2-1:0] shifted;

    assign prod    = W2'(a) * W2'(b);
    assign shifted = prod >>> FRAC;
    assign res     = W'(sat_w(SAT_MAX_W'(shifted), W));

endmodule

// File: rtl/backprop_engine_n.sv
// Single-neuron back-propagation engine: accumulates sum(p*w) one channel per
// cycle, then produces upstream error and updated weights one channel per cycle.
module backprop_engine_n
    import backprop_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 32,
    parameter int FRAC = DEFAULT_FRAC
) (
    input  logic                bpn_clk,
    input  logic                bpn_rst,
    input  logic                bpn_in_valid,
    output logic                bpn_in_ready,
    input  logic [N_CH*W-1:0]   bpn_p,
    input  logic [N_CH*W-1:0]   bpn_w,
    input  logic [W-1:0]        bpn_bp,
    input  logic [W-1:0]        bpn_tm,
    input  logic [W-1:0]        bpn_td,
    output logic                bpn_out_valid,
    input  logic                bpn_out_ready,
    output logic [N_CH*W-1:0]   bpn_bpc,
    output logic [N_CH*W-1:0]   bpn_wn,
    output logic                bpn_div_err
);

    localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ACC_W = 2 * W + $clog2(N_CH);
    localparam int W1    = W + 1;
    localparam int W2    = 2 * W;
    localparam int W3    = 3 * W;
    localparam int W4    = 3 * W + 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(N_CH - 1);

    bpn_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic                     div_err_reg;
    logic signed [W-1:0]      bp_reg;
    logic signed [W-1:0]      tm_reg;
    logic signed [W-1:0]      td_reg;

    logic signed [W-1:0]      p_arr [N_CH];
    logic signed [W-1:0]      w_arr [N_CH];

    logic                     accept;
    logic                     gate;
    logic                     td_zero;
    logic                     last_update;
    logic signed [W-1:0]      p_cur;
    logic signed [W-1:0]      w_cur;
    logic signed [W-1:0]      mul_a;
    logic signed [W-1:0]      mul_b;
    logic signed [W2-1:0]     mul_prod;
    logic signed [W-1:0]      mul_res;
    logic signed [W2-1:0]     pb_prod;
    logic signed [W2-1:0]     pb_shift;
    logic signed [W3-1:0]     scaled;
    logic signed [W1-1:0]     den;
    logic signed [W3-1:0]     quot;
    logic signed [W3-1:0]     step;
    logic signed [W4-1:0]     wn_full;
    logic signed [W-1:0]      wn_val;
    logic signed [W-1:0]      bpc_val;

    assign accept       = bpn_in_valid & in_ready_reg;
    assign gate         = ~acc_reg[ACC_W-1];
    assign td_zero      = (td_reg == '0);
    assign last_update  = (state_reg == ST_UPDATE) && (cnt_reg == LAST_CH);
    assign p_cur        = p_arr[cnt_reg];
    assign w_cur        = w_arr[cnt_reg];

    // One multiplier serves p*w during ACCUM and w*bp during UPDATE.
    always_comb begin
        mul_a = w_cur;
        mul_b = bp_reg;
        if (state_reg == ST_ACCUM) begin
            mul_a = p_cur;
            mul_b = w_cur;
        end
    end

    fixed_mul #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul (
        .a    (mul_a),
        .b    (mul_b),
        .prod (mul_prod),
        .res  (mul_res)
    );

    // Weight step kept at full width; the divisor is forced non-zero so the
    // divider never sees 0 (the td==0 result is suppressed anyway).
    assign pb_prod  = W2'(p_cur) * W2'(bp_reg);
    assign pb_shift = pb_prod >>> FRAC;
    assign scaled   = W3'(pb_shift) * W3'(tm_reg);
    assign den      = td_zero ? W1'(1) : {td_reg, 1'b0};
    assign quot     = scaled / W3'(den);
    assign step     = (gate && !td_zero) ? quot : '0;
    assign wn_full  = W4'(w_cur) - W4'(step);
    assign wn_val   = W'(sat_w(SAT_MAX_W'(wn_full), W));
    assign bpc_val  = gate ? mul_res : '0;

    always_ff @(posedge bpn_clk) begin
        if (bpn_rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            div_err_reg   <= 1'b0;
            bp_reg        <= '0;
            tm_reg        <= '0;
            td_reg        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg    <= ST_ACCUM;
                        in_ready_reg <= 1'b0;
                        cnt_reg      <= '0;
                        acc_reg      <= '0;
                        bp_reg       <= bpn_bp;
                        tm_reg       <= bpn_tm;
                        td_reg       <= bpn_td;
                    end
                end
                ST_ACCUM: begin
                    acc_reg <= acc_reg + ACC_W'(mul_prod);
                    if (cnt_reg == LAST_CH) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_UPDATE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (cnt_reg == LAST_CH) begin
                        cnt_reg       <= '0;
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                        div_err_reg   <= td_zero;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bpn_out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-channel operand capture, result staging and output registers.
    // Results are staged internally and published only on entry to DONE.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [W-1:0] p_reg;
            logic signed [W-1:0] w_reg;
            logic signed [W-1:0] bpc_buf_reg;
            logic signed [W-1:0] wn_buf_reg;
            logic signed [W-1:0] bpc_out_reg;
            logic signed [W-1:0] wn_out_reg;

            always_ff @(posedge bpn_clk) begin
                if (accept) begin
                    p_reg <= bpn_p[gi*W +: W];
                    w_reg <= bpn_w[gi*W +: W];
                end
                if ((state_reg == ST_UPDATE) && (cnt_reg == CNT_W'(gi))) begin
                    bpc_buf_reg <= bpc_val;
                    wn_buf_reg  <= wn_val;
                end
            end

            always_ff @(posedge bpn_clk) begin
                if (bpn_rst) begin
                    bpc_out_reg <= '0;
                    wn_out_reg  <= '0;
                end else if (last_update) begin
                    bpc_out_reg <= (cnt_reg == CNT_W'(gi)) ? bpc_val : bpc_buf_reg;
                    wn_out_reg  <= (cnt_reg == CNT_W'(gi)) ? wn_val  : wn_buf_reg;
                end
            end

            assign p_arr[gi]           = p_reg;
            assign w_arr[gi]           = w_reg;
            assign bpn_bpc[gi*W +: W]  = bpc_out_reg;
            assign bpn_wn[gi*W +: W]   = wn_out_reg;
        end
    endgenerate

    assign bpn_in_ready  = in_ready_reg;
    assign bpn_out_valid = out_valid_reg;
    assign bpn_div_err   = div_err_reg;

endmodule

// File: tb/tb_backprop_engine_n.sv
// Scoreboard bench for backprop_engine_n: directed fixed-point vectors,
// back-pressure and mid-job reset, plus randomized jobs against a wide model.
module tb_backprop_engine_n;

    localparam int N_CH = 4;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic                bpn_clk = 1'b0;
    logic                bpn_rst;
    logic                bpn_in_valid;
    logic                bpn_in_ready;
    logic [N_CH*W-1:0]   bpn_p;
    logic [N_CH*W-1:0]   bpn_w;
    logic [W-1:0]        bpn_bp;
    logic [W-1:0]        bpn_tm;
    logic [W-1:0]        bpn_td;
    logic                bpn_out_valid;
    logic                bpn_out_ready;
    logic [N_CH*W-1:0]   bpn_bpc;
    logic [N_CH*W-1:0]   bpn_wn;
    logic                bpn_div_err;

    always #5 bpn_clk = ~bpn_clk;

    backprop_engine_n #(
        .N_CH (N_CH),
        .W    (W),
        .FRAC (FRAC)
    ) dut (
        .bpn_clk       (bpn_clk),
        .bpn_rst       (bpn_rst),
        .bpn_in_valid  (bpn_in_valid),
        .bpn_in_ready  (bpn_in_ready),
        .bpn_p         (bpn_p),
        .bpn_w         (bpn_w),
        .bpn_bp        (bpn_bp),
        .bpn_tm        (bpn_tm),
        .bpn_td        (bpn_td),
        .bpn_out_valid (bpn_out_valid),
        .bpn_out_ready (bpn_out_ready),
        .bpn_bpc       (bpn_bpc),
        .bpn_wn        (bpn_wn),
        .bpn_div_err   (bpn_div_err)
    );

    typedef struct packed {
        logic [N_CH-1:0][W-1:0] bpc;
        logic [N_CH-1:0][W-1:0] wn;
        logic                   div_err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   job_id   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sat32(input logic signed [127:0] x);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        if (x > hi) return 32'h7FFF_FFFF;
        if (x < lo) return 32'h8000_0000;
        return x[31:0];
    endfunction

    // Reference computed in 128-bit signed arithmetic, straight from the formulas.
    function automatic exp_t model(input logic [N_CH*W-1:0] p, input logic [N_CH*W-1:0] w,
                                   input logic [W-1:0] bp, input logic [W-1:0] tm,
                                   input logic [W-1:0] td);
        exp_t e;
        logic signed [127:0] sum, pi, wi, b, m, d, t;
        logic gate;
        b = $signed(bp);
        m = $signed(tm);
        d = $signed(td);
        sum = 0;
        for (int i = 0; i < N_CH; i++) begin
            pi = $signed(p[i*W +: W]);
            wi = $signed(w[i*W +: W]);
            sum = sum + pi * wi;
        end
        gate = (sum >= 0);
        e.div_err = (td == '0);
        for (int i = 0; i < N_CH; i++) begin
            pi = $signed(p[i*W +: W]);
            wi = $signed(w[i*W +: W]);
            e.bpc[i] = gate ? sat32((wi * b) >>> FRAC) : '0;
            if (td == '0) begin
                e.wn[i] = w[i*W +: W];
            end else begin
                t = ((pi * b) >>> FRAC) * m;
                t = t / (2 * d);
                e.wn[i] = sat32(wi - (gate ? t : 128'sd0));
            end
        end
        return e;
    endfunction

    task automatic send_job(input logic [N_CH*W-1:0] p, input logic [N_CH*W-1:0] w,
                            input logic [W-1:0] bp, input logic [W-1:0] tm,
                            input logic [W-1:0] td, input exp_t e, input bit push);
        int n = 0;
        if (push) sb_q.push_back(e);
        @(negedge bpn_clk);
        bpn_p = p;
        bpn_w = w;
        bpn_bp = bp;
        bpn_tm = tm;
        bpn_td = td;
        bpn_in_valid = 1'b1;
        while (!bpn_in_ready && n < 50) begin
            @(negedge bpn_clk);
            n++;
        end
        check_eq("accept_ready", 64'(bpn_in_ready), 64'd1);
        @(posedge bpn_clk);
        #1;
        bpn_in_valid = 1'b0;
    endtask

    // Called right after the accept edge; that edge closes cycle 0.
    task automatic collect(input int hold, input bit valid_on_release);
        int   k = 1;
        exp_t e;
        @(negedge bpn_clk);
        while (!bpn_out_valid && k < 100) begin
            @(negedge bpn_clk);
            k++;
        end
        check_eq("latency", 64'(k), 64'(2 * N_CH + 1));
        for (int h = 0; h < hold; h++) begin
            bpn_in_valid = (h % 2 == 0);
            @(negedge bpn_clk);
            check_eq("hold_in_ready", 64'(bpn_in_ready), 64'd0);
            check_eq("hold_out_valid", 64'(bpn_out_valid), 64'd1);
        end
        check_eq("sb_size", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < N_CH; i++) begin
                check_eq($sformatf("job%0d_bpc%0d", job_id, i), 64'(bpn_bpc[i*W +: W]), 64'(e.bpc[i]));
                check_eq($sformatf("job%0d_wn%0d", job_id, i), 64'(bpn_wn[i*W +: W]), 64'(e.wn[i]));
            end
            check_eq($sformatf("job%0d_div_err", job_id), 64'(bpn_div_err), 64'(e.div_err));
        end
        $display("job %0d: latency=%0d bpc0=%08h wn0=%08h div_err=%0b", job_id, k,
                 bpn_bpc[W-1:0], bpn_wn[W-1:0], bpn_div_err);
        job_id++;
        bpn_out_ready = 1'b1;
        bpn_in_valid = valid_on_release;
        @(negedge bpn_clk);
        bpn_out_ready = 1'b0;
        bpn_in_valid = 1'b0;
        check_eq("release_in_ready", 64'(bpn_in_ready), 64'd1);
        check_eq("release_out_valid", 64'(bpn_out_valid), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [N_CH*W-1:0] rp, rw;
        logic [W-1:0] rbp, rtm, rtd;
        bpn_rst = 1'b1;
        bpn_in_valid = 1'b0;
        bpn_out_ready = 1'b0;
        bpn_p = '0;
        bpn_w = '0;
        bpn_bp = '0;
        bpn_tm = '0;
        bpn_td = '0;
        repeat (3) @(posedge bpn_clk);
        @(negedge bpn_clk);
        check_eq("rst_in_ready", 64'(bpn_in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bpn_out_valid), 64'd0);
        check_eq("rst_bpc", 64'(bpn_bpc[63:0]), 64'd0);
        check_eq("rst_wn", 64'(bpn_wn[63:0]), 64'd0);
        check_eq("rst_div_err", 64'(bpn_div_err), 64'd0);
        bpn_rst = 1'b0;

        // p=1.0, w=0.5, bp=1.0, tm=1, td=1
        e.bpc = {N_CH{32'h0000_8000}};
        e.wn = '0;
        e.div_err = 1'b0;
        send_job({N_CH{32'h0001_0000}}, {N_CH{32'h0000_8000}}, 32'h0001_0000, 32'd1, 32'd1, e, 1'b1);
        collect(0, 1'b0);

        // w=-0.5 -> gate closed
        e.bpc = '0;
        e.wn = {N_CH{32'hFFFF_8000}};
        e.div_err = 1'b0;
        send_job({N_CH{32'h0001_0000}}, {N_CH{32'hFFFF_8000}}, 32'h0001_0000, 32'd1, 32'd1, e, 1'b1);
        collect(0, 1'b0);

        // td=0 -> weights unchanged, div_err
        e.bpc = {N_CH{32'h0000_8000}};
        e.wn = {N_CH{32'h0000_8000}};
        e.div_err = 1'b1;
        send_job({N_CH{32'h0001_0000}}, {N_CH{32'h0000_8000}}, 32'h0001_0000, 32'd1, 32'd0, e, 1'b1);
        collect(0, 1'b0);

        // zero sum opens the gate; huge step saturates negative
        e.bpc = '0;
        e.wn = {N_CH{32'h8000_0000}};
        e.div_err = 1'b0;
        send_job({N_CH{32'h7FFF_0000}}, '0, 32'h7FFF_0000, 32'd1, 32'd1, e, 1'b1);
        collect(0, 1'b0);

        // back-pressure in DONE with in_valid pulsing, in_valid high at release
        e.bpc = {N_CH{32'h0000_8000}};
        e.wn = '0;
        e.div_err = 1'b0;
        send_job({N_CH{32'h0001_0000}}, {N_CH{32'h0000_8000}}, 32'h0001_0000, 32'd1, 32'd1, e, 1'b1);
        collect(5, 1'b1);

        // reset in cycle 3 of a job abandons it
        send_job({N_CH{32'h0002_0000}}, {N_CH{32'h0000_4000}}, 32'h0001_0000, 32'd1, 32'd1, e, 1'b0);
        @(negedge bpn_clk);
        @(negedge bpn_clk);
        @(negedge bpn_clk);
        bpn_rst = 1'b1;
        @(negedge bpn_clk);
        bpn_rst = 1'b0;
        check_eq("midrst_in_ready", 64'(bpn_in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(bpn_out_valid), 64'd0);
        check_eq("midrst_bpc", 64'(bpn_bpc[63:0]), 64'd0);
        check_eq("midrst_wn", 64'(bpn_wn[63:0]), 64'd0);
        check_eq("midrst_div_err", 64'(bpn_div_err), 64'd0);

        e.bpc = {N_CH{32'h0000_8000}};
        e.wn = '0;
        e.div_err = 1'b0;
        send_job({N_CH{32'h0001_0000}}, {N_CH{32'h0000_8000}}, 32'h0001_0000, 32'd1, 32'd1, e, 1'b1);
        collect(0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_CH; i++) begin
                rp[i*W +: W] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
                rw[i*W +: W] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
            end
            rbp = (r % 3 == 0) ? $urandom : 32'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
            rtm = 32'($urandom_range(0, 8)) - 32'd4;
            rtd = 32'($urandom_range(0, 6)) - 32'd3;
            send_job(rp, rw, rbp, rtm, rtd, model(rp, rw, rbp, rtm, rtd), 1'b1);
            collect(0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
